// File: rtl/servo_pkg.sv
// Shared definitions for the servo ramp controller: widths, default
// pulse-width limits, FSM states and the clamp / slew helpers.
package servo_pkg;

    localparam int US_W            = 12;
    localparam int TICKS_PER_US    = 25;
    localparam int FRAME_TICKS_DEF = 500000;

    localparam int MIN_US_DEF    = 1000;
    localparam int MAX_US_DEF    = 2000;
    localparam int CENTER_US_DEF = 1500;
    localparam int STEP_US_DEF   = 10;

    typedef enum logic {
        IDLE   = 1'b0,
        UPDATE = 1'b1
    } state_t;

    // Limit a requested pulse width to the legal [lo, hi] window.
    function automatic logic [US_W-1:0] clamp_us(
        input logic [US_W-1:0] v,
        input logic [US_W-1:0] lo,
        input logic [US_W-1:0] hi
    );
        logic [US_W-1:0] r;
        if (v < lo)      r = lo;
        else if (v > hi) r = hi;
        else             r = v;
        return r;
    endfunction

    // Move cur toward tgt by at most step. The comparison comes first so
    // every subtraction is of a smaller value from a larger one.
    function automatic logic [US_W-1:0] step_toward(
        input logic [US_W-1:0] cur,
        input logic [US_W-1:0] tgt,
        input logic [US_W-1:0] step
    );
        logic [US_W-1:0] r;
        r = cur;
        if (cur < tgt) begin
            r = ((tgt - cur) <= step) ? tgt : cur + step;
        end else if (cur > tgt) begin
            r = ((cur - tgt) <= step) ? tgt : cur - step;
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_frame_timer.sv
// Free-running servo frame counter; flags the last cycle of each frame.
module servo_frame_timer
    import servo_pkg::*;
#(
    parameter int FRAME_TICKS = FRAME_TICKS_DEF
) (
    input  logic CLK,
    input  logic RST,
    output logic frame_tick
);

    localparam int                CNT_W = $clog2(FRAME_TICKS);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(FRAME_TICKS - 1);

    logic [CNT_W-1:0] r_cnt;

    // Count 0..FRAME_TICKS-1 and wrap.
    always_ff @(posedge CLK) begin
        if (RST)                r_cnt <= '0;
        else if (r_cnt == LAST) r_cnt <= '0;
        else                    r_cnt <= r_cnt + 1'b1;
    end

    // Decoded straight from the register so the tick is glitch-free.
    assign frame_tick = (r_cnt == LAST);

endmodule

// File: rtl/servo_ramp_ctrl.sv
// Multi-channel servo slew controller. Commands set clamped per-channel
// targets; once per frame each channel's output moves toward its target
// by at most STEP_US, one channel per cycle.
//
// Handshake: a command transfers on any rising CLK edge where
// cmd_valid && cmd_ready; cmd_ready is high only in IDLE and out of reset,
// and a held cmd_valid simply waits through the UPDATE sweep.
module servo_ramp_ctrl
    import servo_pkg::*;
#(
    parameter int NCH         = 4,
    parameter int FRAME_TICKS = FRAME_TICKS_DEF,
    parameter int STEP_US     = STEP_US_DEF,
    parameter int MIN_US      = MIN_US_DEF,
    parameter int MAX_US      = MAX_US_DEF,
    parameter int CENTER_US   = CENTER_US_DEF
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [$clog2(NCH)-1:0]  cmd_chan,
    input  logic [US_W-1:0]         cmd_us,
    output logic [NCH*32-1:0]       ctrl_us,
    output logic                    frame_tick,
    output logic [NCH-1:0]          moving,
    output logic                    all_settled,
    output logic                    dbg_state
);

    localparam int               IDX_W    = $clog2(NCH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);
    localparam logic [US_W-1:0]  C_MIN    = US_W'(MIN_US);
    localparam logic [US_W-1:0]  C_MAX    = US_W'(MAX_US);
    localparam logic [US_W-1:0]  C_CENTER = US_W'(CENTER_US);
    localparam logic [US_W-1:0]  C_STEP   = US_W'(STEP_US);

    state_t            r_state;
    state_t            w_next_state;
    logic [IDX_W-1:0]  r_idx;
    logic [US_W-1:0]   r_tgt  [NCH];
    logic [US_W-1:0]   r_ctrl [NCH];
    logic              w_accept;
    logic [US_W-1:0]   w_step_val;
    logic [NCH-1:0]    w_moving;

    servo_frame_timer #(
        .FRAME_TICKS (FRAME_TICKS)
    ) u_timer (
        .CLK        (CLK),
        .RST        (RST),
        .frame_tick (frame_tick)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // FSM next state: a frame tick starts a sweep over all channels.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (frame_tick)         w_next_state = UPDATE;
            UPDATE:  if (r_idx == LAST_IDX)  w_next_state = IDLE;
            default:                         w_next_state = IDLE;
        endcase
    end

    // FSM outputs: commands are only taken while idle and out of reset.
    always_comb begin
        cmd_ready = (r_state == IDLE) && !RST;
        dbg_state = (r_state == UPDATE);
    end

    assign w_accept = cmd_valid && cmd_ready;

    // Channel index walks 0..NCH-1 during a sweep and rests at 0 otherwise.
    always_ff @(posedge CLK) begin
        if (RST)                    r_idx <= '0;
        else if (r_state == UPDATE) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
        else                        r_idx <= '0;
    end

    // Targets: latest accepted command per channel, already clamped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) r_tgt[i] <= C_CENTER;
        end else if (w_accept) begin
            r_tgt[cmd_chan] <= clamp_us(cmd_us, C_MIN, C_MAX);
        end
    end

    assign w_step_val = step_toward(r_ctrl[r_idx], r_tgt[r_idx], C_STEP);

    // Outputs: slew the channel currently selected by the sweep.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NCH; i++) r_ctrl[i] <= C_CENTER;
        end else if (r_state == UPDATE) begin
            r_ctrl[r_idx] <= w_step_val;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_lane
        assign ctrl_us[32*g +: 32] = 32'(r_ctrl[g]);
        assign w_moving[g]         = (r_ctrl[g] != r_tgt[g]);
    end

    assign moving      = w_moving;
    assign all_settled = ~|w_moving;

endmodule

// File: tb/tb_servo_ramp_ctrl.sv
// Directed bench for servo_ramp_ctrl with a short frame (100 cycles).
module tb_servo_ramp_ctrl;

    localparam int NCH    = 4;
    localparam int FRAME  = 100;

    logic              CLK;
    logic              RST;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_chan;
    logic [11:0]       cmd_us;
    logic [NCH*32-1:0] ctrl_us;
    logic              frame_tick;
    logic [NCH-1:0]    moving;
    logic              all_settled;
    logic              dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  chan;
        logic [11:0] us;
        logic [11:0] exp_ctrl;
        logic        exp_mov;
    } vec_t;

    vec_t vecs [12];

    servo_ramp_ctrl #(
        .NCH         (NCH),
        .FRAME_TICKS (FRAME)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_chan    (cmd_chan),
        .cmd_us      (cmd_us),
        .ctrl_us     (ctrl_us),
        .frame_tick  (frame_tick),
        .moving      (moving),
        .all_settled (all_settled),
        .dbg_state   (dbg_state)
    );

    // Clock and watchdog
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Checking helpers
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return ctrl_us[32*i +: 32];
    endfunction

    // Driver tasks
    task automatic do_reset();
        @(negedge CLK);
        RST       = 1'b1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    // Advance negedge by negedge until frame_tick is seen (bounded).
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!frame_tick && n < 3*FRAME);
        if (!frame_tick) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_tick: no frame_tick within %0d cycles", 3*FRAME);
        end
    endtask

    // Present a command and hold it until the handshake completes.
    task automatic send_cmd(input logic [1:0] ch, input logic [11:0] us);
        int n;
        cmd_chan  = ch;
        cmd_us    = us;
        cmd_valid = 1'b1;
        n = 0;
        #1;
        while (!cmd_ready && n < 3*FRAME) begin
            @(negedge CLK);
            n++;
        end
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_cmd: cmd_ready stuck low for %0d cycles", n);
        end
        @(negedge CLK);
        cmd_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [11:0] ramp [4];
        logic [11:0] e0, e2, e3;

        // clamp / single-step vectors, each from a fresh 1500 start
        vecs[0]  = '{2'd0, 12'd0,    12'd1490, 1'b1};
        vecs[1]  = '{2'd1, 12'd999,  12'd1490, 1'b1};
        vecs[2]  = '{2'd2, 12'd1000, 12'd1490, 1'b1};
        vecs[3]  = '{2'd3, 12'd1490, 12'd1490, 1'b0};
        vecs[4]  = '{2'd0, 12'd1495, 12'd1495, 1'b0};
        vecs[5]  = '{2'd1, 12'd1500, 12'd1500, 1'b0};
        vecs[6]  = '{2'd2, 12'd1510, 12'd1510, 1'b0};
        vecs[7]  = '{2'd3, 12'd1511, 12'd1510, 1'b1};
        vecs[8]  = '{2'd0, 12'd2000, 12'd1510, 1'b1};
        vecs[9]  = '{2'd1, 12'd2001, 12'd1510, 1'b1};
        vecs[10] = '{2'd2, 12'd4095, 12'd1510, 1'b1};
        vecs[11] = '{2'd3, 12'd1489, 12'd1490, 1'b1};

        ramp[0] = 12'd1510; ramp[1] = 12'd1520; ramp[2] = 12'd1530; ramp[3] = 12'd1535;

        RST       = 1'b1;
        cmd_valid = 1'b0;
        cmd_chan  = '0;
        cmd_us    = '0;

        // ---- reset values, then idle frames ----
        repeat (3) @(negedge CLK);
        for (int i = 0; i < NCH; i++) check($sformatf("rst_lane%0d", i), lane(i), 1500);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_moving", moving, 0);
        check("rst_all_settled", all_settled, 1);
        check("rst_frame_tick", frame_tick, 0);
        check("rst_state", dbg_state, 0);
        RST = 1'b0;
        #1;
        check("release_cmd_ready", cmd_ready, 1);
        wait_tick(n);
        check("first_tick_offset", n, FRAME - 1);
        for (int f = 0; f < 3; f++) begin
            wait_tick(n);
            check($sformatf("idle_period_f%0d", f), n, FRAME);
            for (int i = 0; i < NCH; i++) check($sformatf("idle_lane%0d_f%0d", i, f), lane(i), 1500);
            check($sformatf("idle_settled_f%0d", f), all_settled, 1);
        end

        // ---- table: clamp and first-step boundaries ----
        for (int v = 0; v < 12; v++) begin
            do_reset();
            send_cmd(vecs[v].chan, vecs[v].us);
            wait_tick(n);
            repeat (NCH + 2) @(negedge CLK);
            check($sformatf("vec%0d_ctrl", v), lane(int'(vecs[v].chan)), 32'(vecs[v].exp_ctrl));
            check($sformatf("vec%0d_moving", v), moving[vecs[v].chan], 32'(vecs[v].exp_mov));
            check($sformatf("vec%0d_settled", v), all_settled, 32'(!vecs[v].exp_mov));
        end

        // ---- ch1 ramp to 1535, change appears at t0+3 ----
        do_reset();
        send_cmd(2'd1, 12'd1535);
        e0 = 12'd1500;
        for (int k = 0; k < 4; k++) begin
            wait_tick(n);
            repeat (2) @(negedge CLK);
            check($sformatf("ramp1_hold_f%0d", k), lane(1), 32'(e0));
            @(negedge CLK);
            check($sformatf("ramp1_new_f%0d", k), lane(1), 32'(ramp[k]));
            check($sformatf("ramp1_moving_f%0d", k), moving[1], (k < 3) ? 1 : 0);
            e0 = ramp[k];
        end

        // ---- stall during UPDATE; command at t0 used in same frame ----
        do_reset();
        wait_tick(n);
        cmd_chan  = 2'd0;
        cmd_us    = 12'd1600;
        cmd_valid = 1'b1;
        check("t0_cmd_ready", cmd_ready, 1);
        @(negedge CLK);
        cmd_chan = 2'd3;
        cmd_us   = 12'd0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) @(negedge CLK);
            check($sformatf("stall_ready_t%0d", k), cmd_ready, 0);
            check($sformatf("stall_state_t%0d", k), dbg_state, 1);
            if (k == 2) check("t0_cmd_same_frame", lane(0), 1510);
        end
        @(negedge CLK);
        check("stall_ready_t5", cmd_ready, 1);
        check("stall_state_t5", dbg_state, 0);
        @(negedge CLK);
        cmd_valid = 1'b0;
        check("stall_lane3_unchanged", lane(3), 1500);
        check("stall_moving", moving, 4'b1001);
        wait_tick(n);
        repeat (NCH + 1) @(negedge CLK);
        check("stall_lane3_next", lane(3), 1490);
        check("stall_lane0_next", lane(0), 1520);

        // ---- reverse mid-ramp ----
        do_reset();
        send_cmd(2'd0, 12'd1600);
        for (int k = 1; k <= 2; k++) begin
            wait_tick(n);
            repeat (NCH + 2) @(negedge CLK);
            check($sformatf("rev_up_f%0d", k), lane(0), (k == 1) ? 1510 : 1520);
        end
        send_cmd(2'd0, 12'd1400);
        for (int k = 3; k <= 15; k++) begin
            wait_tick(n);
            repeat (NCH + 2) @(negedge CLK);
            e0 = (k >= 14) ? 12'd1400 : 12'(1510 - 10*(k - 3));
            check($sformatf("rev_dn_f%0d", k), lane(0), 32'(e0));
        end
        check("rev_settled_moving", moving[0], 0);

        // ---- clamped long ramps on ch2 / ch3 ----
        do_reset();
        send_cmd(2'd2, 12'd2500);
        send_cmd(2'd3, 12'd0);
        for (int k = 1; k <= 51; k++) begin
            wait_tick(n);
            repeat (NCH + 2) @(negedge CLK);
            e2 = (k >= 50) ? 12'd2000 : 12'(1500 + 10*k);
            e3 = (k >= 50) ? 12'd1000 : 12'(1500 - 10*k);
            check($sformatf("long_ch2_f%0d", k), lane(2), 32'(e2));
            check($sformatf("long_ch3_f%0d", k), lane(3), 32'(e3));
            check($sformatf("long_settled_f%0d", k), all_settled, (k >= 50) ? 1 : 0);
        end

        // ---- reset pulsed mid-UPDATE ----
        do_reset();
        send_cmd(2'd0, 12'd2000);
        send_cmd(2'd3, 12'd1000);
        wait_tick(n);
        wait_tick(n);
        wait_tick(n);
        repeat (2) @(negedge CLK);
        check("mid_pre_lane0", lane(0), 1530);
        check("mid_pre_lane3", lane(3), 1480);
        RST = 1'b1;
        @(negedge CLK);
        for (int i = 0; i < NCH; i++) check($sformatf("mid_rst_lane%0d", i), lane(i), 1500);
        check("mid_rst_ready", cmd_ready, 0);
        check("mid_rst_moving", moving, 0);
        check("mid_rst_settled", all_settled, 1);
        check("mid_rst_state", dbg_state, 0);
        check("mid_rst_tick", frame_tick, 0);
        @(negedge CLK);
        check("mid_rst_ready_hold", cmd_ready, 0);
        RST = 1'b0;
        wait_tick(n);
        check("mid_rst_first_tick", n, FRAME - 1);
        wait_tick(n);
        check("mid_rst_period", n, FRAME);
        check("mid_rst_lane0_after", lane(0), 1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/servo_ramp_ctrl.md
# servo_ramp_ctrl

Multi-channel servo motion controller for the robotic arm. It accepts per-joint target pulse widths in µs over a valid/ready command port and clamps each one to a safe range. Once per 20 ms servo frame it slews each joint's commanded pulse width toward its target by at most `STEP_US`. Each `ctrl_us` lane drives the `control` input of one `servo_sg90` PWM instance, so joints move smoothly instead of jumping.

## Interface
- `NCH`, 4: number of servo channels (joints); power of two, 2..8.
- `FRAME_TICKS`, 500000: CLK cycles per servo frame (20 ms at 25 MHz); must be > `NCH`+1.
- `STEP_US`, 10: maximum change of a channel's pulse width per frame, µs.
- `MIN_US`, 1000: lowest legal pulse width, µs.
- `MAX_US`, 2000: highest legal pulse width, µs.
- `CENTER_US`, 1500: reset pulse width and reset target for every channel, µs.

Ports:
- `CLK` in 1: system clock, 25 MHz.
- `RST` in 1: synchronous, active-high reset.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted on the cycle where `cmd_valid && cmd_ready`.
- `cmd_chan` in $clog2(NCH): target channel index.
- `cmd_us` in 12: requested pulse width, µs, unsigned.
- `ctrl_us` out NCH*32: per-channel pulse width, µs; lane i is bits [32i+31:32i], zero-extended from 12 bits.
- `frame_tick` out 1: one-cycle pulse on the last cycle of each frame.
- `moving` out NCH: bit i is high while `ctrl_us[i]` ≠ `target[i]`.
- `all_settled` out 1: high when `moving` is all zero.

## Operation
- Frame counter runs 0..`FRAME_TICKS`-1 and wraps to 0.
  - `frame_tick` = (counter == `FRAME_TICKS`-1), decoded directly from the counter register.
- FSM has two states, `IDLE` and `UPDATE`.
  - `IDLE`: `cmd_ready`=1. When `frame_tick` is high, go to `UPDATE` with idx=0.
  - `UPDATE`: `cmd_ready`=0. Process channel idx, then idx++. After idx==`NCH`-1, return to `IDLE`.
- Command accept: `target[cmd_chan]` ← clamp(`cmd_us`, `MIN_US`, `MAX_US`).
  - Later commands to the same channel overwrite earlier ones; there is no queue.
- Channel update (all arithmetic is 12-bit unsigned; compare before subtracting, so no signed overflow):
  - cur < tgt: cur ← (tgt-cur ≤ `STEP_US`) ? tgt : cur+`STEP_US`.
  - cur > tgt: cur ← (cur-tgt ≤ `STEP_US`) ? tgt : cur-`STEP_US`.
  - cur == tgt: no change.
- `moving` and `all_settled` are combinational from the `ctrl_us` and target registers.
- Reset values:
  - All `ctrl_us` and targets = `CENTER_US`.
  - Frame counter = 0, state = `IDLE`.
  - `cmd_ready`=0 while `RST` is high and 1 in the first cycle after.
  - `moving`=0, `all_settled`=1, `frame_tick`=0.

## Timing
- Let t0 be the cycle where `frame_tick` is high. The FSM is in `UPDATE` for cycles t0+1..t0+`NCH`.
- New `ctrl_us[i]` is visible from cycle t0+2+i onward and stays stable until the next frame.
- Command accepted in cycle t0 (still `IDLE`): its target is used by this frame's update.
- A `cmd_valid` held during `UPDATE` stalls and is accepted at t0+`NCH`+1.
- Command value below `MIN_US` or above `MAX_US` is clamped. A value of 0 writes `MIN_US`.
- `RST` asserted mid-`UPDATE` aborts the update. The next cycle shows reset values: all channels `CENTER_US`, counter 0.
- Steady state: 1 command per cycle while `IDLE`, no back-to-back restrictions.

## Structure
- Shared package `servo_pkg` holds:
  - `US_W`=12, `TICKS_PER_US`=25, `FRAME_TICKS_DEF`=500000.
  - Default `MIN_US`/`MAX_US`/`CENTER_US`/`STEP_US`.
  - The FSM state enum.
- Sub-module `servo_frame_timer` (params `FRAME_TICKS`; ports `CLK`, `RST`, `frame_tick`) holds the counter.
- Top level holds the FSM, target and ctrl register arrays, clamp logic and step logic.

## Test plan
Bench uses `FRAME_TICKS`=100, `NCH`=4, defaults otherwise.
- Reset release, then 3 frames with no commands -> every `ctrl_us` lane = 1500, `all_settled`=1, `frame_tick` pulses every 100 cycles.
- cmd ch1=1535 in `IDLE` -> ch1 reads 1510, 1520, 1530, 1535 over 4 frames, with each change appearing at t0+3. `moving[1]` falls when 1535 is reached.
- cmd ch2=2500, then cmd ch3=0 -> targets clamp to 2000 and 1000. ch2 rises 10/frame and ch3 falls 10/frame, both settling after 50 frames.
- `cmd_valid` held from t0+1 -> `cmd_ready`=0 for 4 cycles and the accept happens at t0+5. A command in cycle t0 is applied in the same frame.
- Reverse mid-ramp: ch0 target 1600, two frames (ch0=1520), then target 1400 -> ch0 next frame = 1510, then continues down 10/frame to 1400.
- `RST` pulsed at t0+2 during a ramp -> from the next cycle all lanes = 1500, `cmd_ready`=0 while `RST` is high, first `frame_tick` 100 cycles after release.
